fdtd_wt_stream_gen: RTL
=======================

Name: fdtd_wt_stream_gen

Overview:
Upstream feeder for the FDTD single-word AXI write engine. Accepts a stream of result words from the FDTD compute datapath via valid/ready and buffers them in a small FIFO. Generates a strided word-address sequence from a programmed base, and drives the engine's req/gnt write interface one word at a time. Signals completion once every programmed word has been granted.

Parameters:
AXI4_ADDR_WIDTH, 32, byte-address width; word addresses are AXI4_ADDR_WIDTH-2 bits.
AXI4_DATA_WIDTH, 32, width of data words.
FIFO_DEPTH, 4, input buffer depth in words; must be a power of 2 and at least 2.
CNT_WIDTH, 16, width of the word-count field.

Ports:
ACLK  in  1  clock; all logic on its rising edge.
ARESET  in  1  reset, synchronous, active-high.
start_i  in  1  single-cycle job start; sampled only in IDLE.
base_word_addr_i  in  AXI4_ADDR_WIDTH-2  first word address; latched on an accepted start.
stride_i  in  AXI4_ADDR_WIDTH-2  word-address increment per write; latched on an accepted start.
count_i  in  CNT_WIDTH  number of words in the job; latched on an accepted start.
busy_o  out  1  high while in RUN.
done_o  out  1  one-cycle pulse when the job completes.
din_valid_i  in  1  input word valid.
din_data_i  in  AXI4_DATA_WIDTH  input word.
din_ready_o  out  1  input word accepted when din_valid_i and din_ready_o are both high.
wt_req_o  out  1  write request to the write engine.
wt_word_addr_o  out  AXI4_ADDR_WIDTH-2  write word address.
wt_data_o  out  AXI4_DATA_WIDTH  write data.
wt_gnt_i  in  1  write complete; the engine raises this after its write response arrives.

Behaviour:
- Reset: ARESET high at a clock edge clears the FSM to IDLE, empties the FIFO, and zeroes all counters and the address register. All outputs are 0 from the following cycle.
- Reset mid-job: the job is abandoned; no done_o pulse is issued. The write engine must be reset together with this block.
- FSM states IDLE, RUN, DONE.
  - IDLE, start_i=1, count_i!=0: latch base, stride and count; go to RUN.
  - IDLE, start_i=1, count_i=0: go to DONE directly; no input is accepted and no writes are issued.
  - RUN: go to DONE on the cycle a grant brings the granted count up to the latched count.
  - DONE: done_o=1 for exactly one cycle, then return to IDLE.
  - start_i is ignored in RUN and DONE.
- busy_o = (state==RUN).
- Input side:
  - din_ready_o = RUN and FIFO not full and accepted_cnt < count.
  - Words beyond count are never accepted.
  - din_ready_o depends only on registered state. There is no combinational path from wt_gnt_i to din_ready_o, so a full FIFO keeps ready low even in a pop cycle.
  - A push and a pop in the same cycle are legal whenever the FIFO is neither full nor empty before the edge.
- Output side:
  - wt_req_o = RUN and FIFO not empty.
  - wt_data_o = FIFO head.
  - wt_word_addr_o = current address register.
  - All three are driven from registers only.
- Handshake rules:
  - Once wt_req_o is high, it stays high and wt_word_addr_o and wt_data_o stay unchanged until the cycle wt_gnt_i is sampled high.
  - On a cycle with wt_req_o and wt_gnt_i both high: pop the FIFO, increment granted_cnt, and set addr <= addr + stride.
  - The address addition is modulo 2^(AXI4_ADDR_WIDTH-2) and wraps silently.
  - Back-to-back requests: if the FIFO still holds data after a pop, wt_req_o remains high in the next cycle and presents the next head and the new address.
  - wt_gnt_i while wt_req_o is low is ignored.
- Latency: a word accepted at edge N into an empty FIFO appears with wt_req_o=1 in the cycle after edge N.
- The first address is base_word_addr_i. Data order is FIFO order, which is the same as acceptance order.
- Counters are CNT_WIDTH bits wide and cannot overflow, because both are bounded by the latched count.

Test Plan:
- Basic job: start with base=0x100, stride=1, count=3; feed 0xA, 0xB, 0xC; grant 2 cycles after each req -> three requests (0x100,0xA), (0x101,0xB), (0x102,0xC); done_o pulses once, the cycle after the state reaches DONE.
- Empty job: start with count=0 -> done_o high two cycles after start; wt_req_o and din_ready_o never rise; busy_o stays 0.
- Backpressure: FIFO_DEPTH=4, count=8, din_valid_i held high, wt_gnt_i held low for 20 cycles -> din_ready_o falls after exactly 4 accepts; after gnt is released, all 8 words are written in order and a 9th offered word is never accepted.
- Stability and back-to-back: stride=4, base=0x10, random gnt delays of 0-5 cycles -> addresses 0x10, 0x14, 0x18, ...; an assertion confirms addr and data stay stable while req is high and gnt is low; a gnt in consecutive cycles keeps req high continuously.
- Wrap: base=0x3FFFFFFF, stride=1, count=2 -> addresses 0x3FFFFFFF then 0x00000000.
- Reset and ignored start: assert ARESET after 1 of 4 grants -> all outputs 0 in the next cycle and no done_o; start_i pulsed during RUN of a fresh job -> latched base and count unchanged.

Source files
------------

// File: rtl/fdtd_wt_stream_gen.sv
// Purpose: buffer FDTD result words and feed them to the single-word write engine at strided word addresses.
// Latency: a word pushed into an empty FIFO is presented with wt_req_o one cycle after its acceptance edge.
// Backpressure: din_ready_o drops when the FIFO is full or the whole job has been accepted; requests hold until granted.

// Generic synchronous FIFO; head is always visible on rdata.
// Latency: one cycle from push to visibility on rdata/!empty.
// Backpressure: caller must not push when full or pop when empty.
module fdtd_wt_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic [WIDTH-1:0] mem [DEPTH];

   // Storage and pointer update; storage is cleared so the head reads 0 after reset.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   assign rdata = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// Job sequencer: latches base/stride/count, pairs FIFO words with strided addresses.
// Latency: req one cycle after first accept; done_o one cycle after the job reaches DONE.
// Backpressure: input stalls on full FIFO or exhausted count; output holds until wt_gnt_i.
module fdtd_wt_stream_gen #(
   parameter int AXI4_ADDR_WIDTH = 32,
   parameter int AXI4_DATA_WIDTH = 32,
   parameter int FIFO_DEPTH      = 4,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                       ACLK,
   input  logic                       ARESET,
   input  logic                       start_i,
   input  logic [AXI4_ADDR_WIDTH-3:0] base_word_addr_i,
   input  logic [AXI4_ADDR_WIDTH-3:0] stride_i,
   input  logic [CNT_WIDTH-1:0]       count_i,
   output logic                       busy_o,
   output logic                       done_o,
   input  logic                       din_valid_i,
   input  logic [AXI4_DATA_WIDTH-1:0] din_data_i,
   output logic                       din_ready_o,
   output logic                       wt_req_o,
   output logic [AXI4_ADDR_WIDTH-3:0] wt_word_addr_o,
   output logic [AXI4_DATA_WIDTH-1:0] wt_data_o,
   input  logic                       wt_gnt_i
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t                     state_q;
   state_t                     state_d;
   logic [AXI4_ADDR_WIDTH-3:0] addr_q;
   logic [AXI4_ADDR_WIDTH-3:0] stride_q;
   logic [CNT_WIDTH-1:0]       count_q;
   logic [CNT_WIDTH-1:0]       accepted_cnt;
   logic [CNT_WIDTH-1:0]       granted_cnt;
   logic                       done_q;

   logic                       fifo_full;
   logic                       fifo_empty;
   logic                       push;
   logic                       pop;
   logic                       start_job;
   logic                       last_grant;

   // Handshake qualifiers; ready and req derive from registered state only.
   assign din_ready_o = (state_q == RUN) && !fifo_full && (accepted_cnt < count_q);
   assign wt_req_o    = (state_q == RUN) && !fifo_empty;
   assign push        = din_valid_i && din_ready_o;
   assign pop         = wt_req_o && wt_gnt_i;
   assign start_job   = (state_q == IDLE) && start_i && (count_i != '0);
   assign last_grant  = pop && ((granted_cnt + 1'b1) == count_q);

   assign busy_o         = (state_q == RUN);
   assign done_o         = done_q;
   assign wt_word_addr_o = addr_q;

   fdtd_wt_fifo #(
      .WIDTH (AXI4_DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .push   (push),
      .wdata  (din_data_i),
      .pop    (pop),
      .rdata  (wt_data_o),
      .full   (fifo_full),
      .empty  (fifo_empty)
   );

   // State register.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic; a zero-length job skips RUN entirely.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = (count_i == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (last_grant) begin
               state_d = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Job parameters, counters and the strided address; address wraps modulo its width.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         addr_q       <= '0;
         stride_q     <= '0;
         count_q      <= '0;
         accepted_cnt <= '0;
         granted_cnt  <= '0;
      end else if (start_job) begin
         addr_q       <= base_word_addr_i;
         stride_q     <= stride_i;
         count_q      <= count_i;
         accepted_cnt <= '0;
         granted_cnt  <= '0;
      end else begin
         if (push) begin
            accepted_cnt <= accepted_cnt + 1'b1;
         end
         if (pop) begin
            granted_cnt <= granted_cnt + 1'b1;
            addr_q      <= addr_q + stride_q;
         end
      end
   end

   // Completion pulse is registered, so it follows the DONE state by one cycle.
   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         done_q <= 1'b0;
      end else begin
         done_q <= (state_q == DONE);
      end
   end
endmodule
